data_memory_arbiter: RTL

//  Two-port arbiter/sequencer in front of the single-port data_memory.

---
 rtl/data_memory_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Each granted request runs IDLE -> ACCESS -> RESP and returns a one-cycle ack to its port.
module data_memory_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MEM_DEPTH_LOG2 = 5,
  parameter bit          ROUND_ROBIN    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  // Port A (load/store unit)
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  // Port B (debug/DMA)
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  // Memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic PortA = 1'b0;
  localparam logic PortB = 1'b1;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic                id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

  logic grant_valid;
  logic grant_id;
  logic in_range;

  assign in_range = ((addr_q >> MEM_DEPTH_LOG2) == '0);

  // On a tie the port that did not win last time gets the grant (or A in fixed-priority mode).
  always_comb begin
    grant_valid = a_req | b_req;
    if (a_req && b_req) begin
      grant_id = ROUND_ROBIN ? ~last_q : PortA;
    end else begin
      grant_id = a_req ? PortA : PortB;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    we_d      = we_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          id_d    = grant_id;
          last_d  = grant_id;
          we_d    = (grant_id == PortA) ? a_we    : b_we;
          addr_d  = (grant_id == PortA) ? a_addr  : b_addr;
          wdata_d = (grant_id == PortA) ? a_wdata : b_wdata;
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Out-of-range reads return zero; writes leave the port's rdata untouched.
        if (!we_q) begin
          if (id_q == PortA) begin
            a_rdata_d = in_range ? read_data : '0;
          end else begin
            b_rdata_d = in_range ? read_data : '0;
          end
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      last_q    <= PortB;
      we_q      <= 1'b0;
      id_q      <= PortA;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      we_q      <= we_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    mem_read   = (state_q == StAccess) && in_range && !we_q;
    mem_write  = (state_q == StAccess) && in_range && we_q;
    endereco   = addr_q;
    write_data = wdata_q;
    a_ack      = (state_q == StResp) && (id_q == PortA);
    b_ack      = (state_q == StResp) && (id_q == PortB);
    a_err      = a_ack && !in_range;
    b_err      = b_ack && !in_range;
    a_rdata    = a_rdata_q;
    b_rdata    = b_rdata_q;
    busy       = (state_q != StIdle);
  end

endmodule
